rd_fram_unpack: RTL and testbench
=================================

# rd_fram_unpack

Read-side frame buffer for the DDR→HDMI path. Fetches fixed-length bursts of 256-bit words from the DDR read port into a local buffer and unpacks them into 32-bit pixels on a valid/ready stream toward the video timing/output logic. It is the counterpart of the write-side frame buffer, which packs 32-bit pixels into 256-bit DDR words. Single clock domain.

## Interface
- DDR_DATA_WIDTH, 256: DDR read word width
- PIX_DATA_WIDTH, 32: pixel width; DDR_DATA_WIDTH must be an integer multiple
- BUF_ADDR_WIDTH, 4: local buffer depth is 2**BUF_ADDR_WIDTH DDR words
- BURST_LEN, 4: DDR words per read request; must be ≤ 2**BUF_ADDR_WIDTH
- DDR_ADDR_WIDTH, 20: word address width
- FRAME_WORDS, 115200: DDR words per frame; must be a multiple of BURST_LEN

Ports:
- rd_clk  in  1  sole clock
- rd_rst  in  1  reset, synchronous, active-high
- frame_start  in  1  one-cycle pulse: flush and restart at address 0
- ddr_rd_req  out  1  burst request
- ddr_rd_addr  out  DDR_ADDR_WIDTH  burst start word address, stable while req high
- ddr_rd_ack  in  1  request accepted
- ddr_rd_data_valid  in  1  one read beat; no backpressure
- ddr_rd_data  in  DDR_DATA_WIDTH  read beat data
- pix_data  out  PIX_DATA_WIDTH  pixel
- pix_valid  out  1  pixel valid
- pix_ready  in  1  sink accepts
- underflow_cnt  out  16  starvation counter (see Configuration)

## Operation
- FSM states: IDLE, REQ, DATA, DRAIN.
- IDLE→REQ when free = depth − count ≥ BURST_LEN. REQ: ddr_rd_req=1 until ddr_rd_ack is sampled high (a raised request is never withdrawn), then DATA. DATA: each valid beat is written to the buffer; after the BURST_LEN-th beat →IDLE, and ddr_rd_addr += BURST_LEN, wrapping to 0 when it reaches FRAME_WORDS.
- Only one burst is outstanding at a time; the free-space check in IDLE guarantees no overflow.
- Lane order: pixel k of a word is ddr_rd_data[k*PIX_DATA_WIDTH +: PIX_DATA_WIDTH], k = 0 first.
- Output stage: one hold register plus a lane index, LANES = DDR_DATA_WIDTH/PIX_DATA_WIDTH. A pixel transfers when pix_valid&pix_ready. The hold register is reloaded from the buffer when it is empty, or when the last lane is transferred and the buffer is non-empty. Back-to-back words give gapless output.
- Push and pop in the same cycle: count unchanged.
- frame_start: buffer count, pointers, hold register and lane index are cleared; ddr_rd_addr=0. In IDLE → IDLE. In REQ → keep req until ack, then DRAIN. In DATA → DRAIN. DRAIN discards all remaining beats of the outstanding burst (the beat counter continues), then →IDLE. Beats arriving during DRAIN are never written.
- rd_rst dominates frame_start.

## Timing
- Reset values: ddr_rd_req=0, ddr_rd_addr=0, pix_valid=0, pix_data=0, underflow_cnt=0, state IDLE, buffer empty.
- Earliest ddr_rd_req: cycle after reset release, if free ≥ BURST_LEN.
- Buffer read latency: 1 cycle. A beat written at cycle N into an empty block gives pix_valid=1 at N+2.
- After the last transfer of a word: the next word's lane 0 is valid the next cycle, if that word was in the buffer at least 1 cycle earlier.
- frame_start at cycle N: pix_valid=0 from N+1.
- Next ddr_rd_req after a burst completes or DRAIN ends: 1 cycle at earliest.

## Configuration
- RD_FRAM_UNDERFLOW_CNT_EN defined: underflow_cnt increments, saturating at 16'hFFFF, every cycle with pix_ready=1 and pix_valid=0 after the first pixel of a frame has been output. Cleared by rd_rst and frame_start.
- Not defined: underflow_cnt tied to 0; no counter logic.

## Structure
- Package rd_fram_pkg: FSM state enum; derived constants LANES and LANE_IDX_W (log2 LANES).
- One sub-module, rd_fram_sdp_buf: simple dual-port RAM, DDR_DATA_WIDTH × 2**BUF_ADDR_WIDTH, synchronous write, 1-cycle registered read.
- Pointers, count, FSM, address counter and unpack logic live in the top module.

## Test plan
- Reset then sink always ready; DDR acks immediately and returns beats with word w = {8 lanes of w*8+k} → pix_data sequence 0,1,2,… with no gaps after the first pixel; ddr_rd_addr steps 0,4,8,….
- Sink never ready → exactly 16 words are fetched (4 bursts), then ddr_rd_req stays 0; when ready goes high, 128 pixels are output in order, then fetching resumes.
- FRAME_WORDS=8, BURST_LEN=4 → addresses 0,4,0,4…; pixel data continues across the wrap.
- frame_start after the 2nd beat of a burst → the remaining 2 beats are discarded, pix_valid=0 next cycle, next req has addr 0, and the first pixel out is word 0 lane 0.
- frame_start while req is high and ack is delayed 5 cycles → req held until ack, 4 beats discarded, then a new req at addr 0.
- With the macro defined: ready held high and DDR stalled 10 cycles after the first pixel → underflow_cnt=10; after frame_start → 0.

Source files
------------

// File: rtl/rd_fram_pkg.sv
// Shared types and derived constants for the read-side frame buffer.
package rd_fram_pkg;

   // Bits needed to index n items; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned DEF_DDR_DATA_WIDTH = 256;
   localparam int unsigned DEF_PIX_DATA_WIDTH = 32;
   localparam int unsigned LANES              = DEF_DDR_DATA_WIDTH / DEF_PIX_DATA_WIDTH;
   localparam int unsigned LANE_IDX_W         = idx_width(LANES);

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StData,
      StDrain
   } rd_state_e;

endpackage

// File: rtl/rd_fram_sdp_buf.sv
// Simple dual-port word buffer: synchronous write, registered 1-cycle read.
// The read register doubles as the unpacker's hold register, so it clears on
// reset and on the flush strobe.
module rd_fram_sdp_buf #(
   parameter int unsigned DATA_WIDTH = 256,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_clr,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic                  i_re,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] r_rdata;

   // Storage array write port.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Registered read port; cleared so a flushed hold word never leaks out.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/rd_fram_unpack.sv
// Read-side frame buffer: fetches fixed-length DDR bursts into a local buffer
// and unpacks each wide word into pixels on a valid/ready stream.
// Optional build macro: RD_FRAM_UNDERFLOW_CNT_EN enables the starvation counter.
module rd_fram_unpack
   import rd_fram_pkg::*;
#(
   parameter int unsigned DDR_DATA_WIDTH = DEF_DDR_DATA_WIDTH,
   parameter int unsigned PIX_DATA_WIDTH = DEF_PIX_DATA_WIDTH,
   parameter int unsigned BUF_ADDR_WIDTH = 4,
   parameter int unsigned BURST_LEN      = 4,
   parameter int unsigned DDR_ADDR_WIDTH = 20,
   parameter int unsigned FRAME_WORDS    = 115200
) (
   input  logic                      i_rd_clk,
   input  logic                      i_rd_rst,
   input  logic                      i_frame_start,
   output logic                      o_ddr_rd_req,
   output logic [DDR_ADDR_WIDTH-1:0] o_ddr_rd_addr,
   input  logic                      i_ddr_rd_ack,
   input  logic                      i_ddr_rd_data_valid,
   input  logic [DDR_DATA_WIDTH-1:0] i_ddr_rd_data,
   output logic [PIX_DATA_WIDTH-1:0] o_pix_data,
   output logic                      o_pix_valid,
   input  logic                      i_pix_ready,
   output logic [15:0]               o_underflow_cnt
);

   localparam int unsigned NUM_LANES = DDR_DATA_WIDTH / PIX_DATA_WIDTH;
   localparam int unsigned LIDX_W    = idx_width(NUM_LANES);
   localparam int unsigned DEPTH     = 2**BUF_ADDR_WIDTH;
   localparam int unsigned CNT_W     = BUF_ADDR_WIDTH + 1;
   localparam int unsigned BEAT_W    = idx_width(BURST_LEN);

   // Highest fill level that still leaves room for a whole burst.
   localparam logic [CNT_W-1:0]          ROOM_LIM  = CNT_W'(DEPTH - BURST_LEN);
   localparam logic [BEAT_W-1:0]         BEAT_LAST = BEAT_W'(BURST_LEN - 1);
   localparam logic [LIDX_W-1:0]         LANE_LAST = LIDX_W'(NUM_LANES - 1);
   localparam logic [DDR_ADDR_WIDTH-1:0] ADDR_STEP = DDR_ADDR_WIDTH'(BURST_LEN);
   // Start address of the final burst of a frame.
   localparam logic [DDR_ADDR_WIDTH-1:0] ADDR_WRAP = DDR_ADDR_WIDTH'(FRAME_WORDS - BURST_LEN);

   rd_state_e                 r_state;
   logic                      r_req;
   logic                      r_flush;
   logic [DDR_ADDR_WIDTH-1:0] r_addr;
   logic [BEAT_W-1:0]         r_beat;

   logic [BUF_ADDR_WIDTH-1:0] r_wr_ptr;
   logic [BUF_ADDR_WIDTH-1:0] r_rd_ptr;
   logic [CNT_W-1:0]          r_cnt;
   logic                      r_hold_vld;
   logic [LIDX_W-1:0]         r_lane;

   logic                      w_push;
   logic                      w_pop;
   logic                      w_xfer;
   logic                      w_last_xfer;
   logic                      w_room;
   logic                      w_beat_last;
   logic [DDR_ADDR_WIDTH-1:0] w_addr_next;
   logic [DDR_DATA_WIDTH-1:0] w_hold;

   // Buffer handshake decode; frame_start suppresses every buffer access.
   always_comb begin
      w_push      = (r_state == StData) && i_ddr_rd_data_valid && !i_frame_start;
      w_xfer      = r_hold_vld && i_pix_ready;
      w_last_xfer = w_xfer && (r_lane == LANE_LAST);
      w_pop       = (r_cnt != '0) && (!r_hold_vld || w_last_xfer) && !i_frame_start;
      w_room      = (r_cnt <= ROOM_LIM);
      w_beat_last = (r_beat == BEAT_LAST);
      w_addr_next = (r_addr >= ADDR_WRAP) ? '0 : r_addr + ADDR_STEP;
   end

   // Burst request FSM with address and beat counters.
   always_ff @(posedge i_rd_clk) begin
      if (i_rd_rst) begin
         r_state <= StIdle;
         r_req   <= 1'b0;
         r_flush <= 1'b0;
         r_addr  <= '0;
         r_beat  <= '0;
      end else begin
         case (r_state)
            StIdle: begin
               if (i_frame_start) begin
                  r_addr <= '0;
               end else if (w_room) begin
                  r_state <= StReq;
                  r_req   <= 1'b1;
               end
            end
            StReq: begin
               // The request and its address stay put until accepted; a restart
               // seen meanwhile is remembered and applied on the ack.
               if (i_ddr_rd_ack) begin
                  r_req   <= 1'b0;
                  r_beat  <= '0;
                  r_flush <= 1'b0;
                  if (r_flush || i_frame_start) begin
                     r_state <= StDrain;
                     r_addr  <= '0;
                  end else begin
                     r_state <= StData;
                  end
               end else if (i_frame_start) begin
                  r_flush <= 1'b1;
               end
            end
            StData: begin
               if (i_ddr_rd_data_valid) begin
                  r_beat <= w_beat_last ? '0 : r_beat + BEAT_W'(1);
               end
               if (i_frame_start) begin
                  r_addr  <= '0;
                  r_state <= (i_ddr_rd_data_valid && w_beat_last) ? StIdle : StDrain;
               end else if (i_ddr_rd_data_valid && w_beat_last) begin
                  r_state <= StIdle;
                  r_addr  <= w_addr_next;
               end
            end
            StDrain: begin
               if (i_frame_start) begin
                  r_addr <= '0;
               end
               if (i_ddr_rd_data_valid) begin
                  r_beat <= w_beat_last ? '0 : r_beat + BEAT_W'(1);
                  if (w_beat_last) begin
                     r_state <= StIdle;
                  end
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   // Buffer pointers, fill count and output lane tracking.
   always_ff @(posedge i_rd_clk) begin
      if (i_rd_rst || i_frame_start) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_cnt      <= '0;
         r_hold_vld <= 1'b0;
         r_lane     <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + BUF_ADDR_WIDTH'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + BUF_ADDR_WIDTH'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
         // A pop lands in the read register next cycle, exactly when lane 0 is due.
         if (w_pop) begin
            r_hold_vld <= 1'b1;
            r_lane     <= '0;
         end else if (w_last_xfer) begin
            r_hold_vld <= 1'b0;
            r_lane     <= '0;
         end else if (w_xfer) begin
            r_lane <= r_lane + LIDX_W'(1);
         end
      end
   end

   rd_fram_sdp_buf #(
      .DATA_WIDTH (DDR_DATA_WIDTH),
      .ADDR_WIDTH (BUF_ADDR_WIDTH)
   ) u_buf (
      .i_clk   (i_rd_clk),
      .i_rst   (i_rd_rst),
      .i_clr   (i_frame_start),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (i_ddr_rd_data),
      .i_re    (w_pop),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_hold)
   );

   assign o_ddr_rd_req  = r_req;
   assign o_ddr_rd_addr = r_addr;
   assign o_pix_valid   = r_hold_vld;
   assign o_pix_data    = w_hold[PIX_DATA_WIDTH*r_lane +: PIX_DATA_WIDTH];

`ifdef RD_FRAM_UNDERFLOW_CNT_EN
   logic        r_seen_pix;
   logic [15:0] r_uf_cnt;

   // Starvation counter: sink ready but nothing to give, once the frame has begun.
   always_ff @(posedge i_rd_clk) begin
      if (i_rd_rst || i_frame_start) begin
         r_seen_pix <= 1'b0;
         r_uf_cnt   <= '0;
      end else begin
         if (w_xfer) begin
            r_seen_pix <= 1'b1;
         end
         if (r_seen_pix && i_pix_ready && !r_hold_vld && (r_uf_cnt != 16'hFFFF)) begin
            r_uf_cnt <= r_uf_cnt + 16'd1;
         end
      end
   end

   assign o_underflow_cnt = r_uf_cnt;
`else
   assign o_underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_rd_fram_unpack.sv
// Directed bench for rd_fram_unpack. A second instance with an 8-word frame
// shares all inputs to show the address wrap.
module tb_rd_fram_unpack;

   logic         clk = 1'b0;
   logic         rst;
   logic         frame_start;
   logic         ack;
   logic         dvalid;
   logic [255:0] ddata;
   logic         ready;

   logic         req,       req_w;
   logic [19:0]  addr,      addr_w;
   logic [31:0]  pix_data,  pix_data_w;
   logic         pix_valid, pix_valid_w;
   logic [15:0]  uf,        uf_w;

   int checks = 0;
   int errors = 0;

   // DDR model controls and observations
   bit          ddr_en     = 1'b0;
   int          ack_dly    = 0;
   bit          model_busy = 1'b0;
   int          beats_total = 0;
   int          ack_cnt    = 0;
   logic [19:0] acked_addr[$];
   logic [19:0] acked_addr_w[$];

   // Pixel capture results
   int pix_q[$];
   int pix_w_q[$];
   int gaps;
   bit pix_to;

   always #5 clk = ~clk;

   rd_fram_unpack dut (
      .i_rd_clk            (clk),
      .i_rd_rst            (rst),
      .i_frame_start       (frame_start),
      .o_ddr_rd_req        (req),
      .o_ddr_rd_addr       (addr),
      .i_ddr_rd_ack        (ack),
      .i_ddr_rd_data_valid (dvalid),
      .i_ddr_rd_data       (ddata),
      .o_pix_data          (pix_data),
      .o_pix_valid         (pix_valid),
      .i_pix_ready         (ready),
      .o_underflow_cnt     (uf)
   );

   rd_fram_unpack #(
      .FRAME_WORDS (8)
   ) dut_w (
      .i_rd_clk            (clk),
      .i_rd_rst            (rst),
      .i_frame_start       (frame_start),
      .o_ddr_rd_req        (req_w),
      .o_ddr_rd_addr       (addr_w),
      .i_ddr_rd_ack        (ack),
      .i_ddr_rd_data_valid (dvalid),
      .i_ddr_rd_data       (ddata),
      .o_pix_data          (pix_data_w),
      .o_pix_valid         (pix_valid_w),
      .i_pix_ready         (ready),
      .o_underflow_cnt     (uf_w)
   );

   // Word w carries pixels w*8+k in lane k.
   function automatic logic [255:0] mk_word(input int w);
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = 32'(w * 8 + k);
      return r;
   endfunction

   // DDR read port model: ack after ack_dly cycles, then 4 back-to-back beats.
   initial begin
      logic [19:0] a;
      ack = 1'b0; dvalid = 1'b0; ddata = '0;
      forever begin
         @(negedge clk);
         if (ddr_en && req && !rst) begin
            model_busy = 1'b1;
            a = addr;
            repeat (ack_dly) @(negedge clk);
            ack = 1'b1;
            acked_addr.push_back(addr);
            acked_addr_w.push_back(addr_w);
            ack_cnt++;
            @(negedge clk);
            ack = 1'b0;
            for (int b = 0; b < 4; b++) begin
               dvalid = 1'b1;
               ddata  = mk_word(int'(a) + b);
               beats_total++;
               @(negedge clk);
            end
            dvalid = 1'b0;
            model_busy = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   // Collects transfers starting at the current negedge; no checking here.
   task automatic get_pixels(input int n, input int budget);
      int cyc = 0;
      bit started = 1'b0;
      pix_q.delete(); pix_w_q.delete(); gaps = 0; pix_to = 1'b0;
      forever begin
         if (pix_valid && ready) begin
            pix_q.push_back(int'(pix_data));
            started = 1'b1;
         end else if (started && !pix_valid) begin
            gaps++;
         end
         if (pix_valid_w && ready) pix_w_q.push_back(int'(pix_data_w));
         if (pix_q.size() >= n) break;
         if (cyc >= budget) begin pix_to = 1'b1; break; end
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic do_reset();
      int t = 0;
      ddr_en = 1'b0;
      while (model_busy && t < 100) begin @(negedge clk); t++; end
      ready = 1'b0; frame_start = 1'b0; ack_dly = 0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      acked_addr.delete(); acked_addr_w.delete();
      beats_total = 0; ack_cnt = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      ddr_en = 1'b0; ready = 1'b0; frame_start = 1'b0; rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", req); end
      checks++; if (addr !== 20'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", addr); end
      checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", pix_valid); end
      checks++; if (pix_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", pix_data); end
      checks++; if (uf !== 16'd0) begin errors++; $display("FAIL reset_uf: got %0d expected 0", uf); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", req); end
      repeat (3) @(negedge clk);
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL req_held: got %b expected 1", req); end
      checks++; if (addr !== 20'd0) begin errors++; $display("FAIL req_addr: got %0d expected 0", addr); end
   endtask

   task automatic test_stream();
      do_reset();
      ready = 1'b1; ddr_en = 1'b1;
      get_pixels(256, 3000);
      checks++; if (pix_to) begin errors++; $display("FAIL stream_timeout: got %0d pixels expected 256", pix_q.size()); end
      for (int i = 0; i < 256; i++) begin
         checks++; if (pix_q[i] !== i) begin errors++; $display("FAIL stream_pix[%0d]: got %0d expected %0d", i, pix_q[i], i); end
         checks++; if (pix_w_q[i] !== i) begin errors++; $display("FAIL wrap_pix[%0d]: got %0d expected %0d", i, pix_w_q[i], i); end
      end
      checks++; if (gaps !== 0) begin errors++; $display("FAIL stream_gaps: got %0d expected 0", gaps); end
      checks++; if (acked_addr.size() < 8) begin errors++; $display("FAIL stream_bursts: got %0d expected >=8", acked_addr.size()); end
      for (int i = 0; i < 8 && i < acked_addr.size(); i++) begin
         checks++; if (acked_addr[i] !== 20'(4 * i)) begin errors++; $display("FAIL stream_addr[%0d]: got %0d expected %0d", i, acked_addr[i], 4 * i); end
         checks++; if (acked_addr_w[i] !== 20'(4 * (i % 2))) begin errors++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", i, acked_addr_w[i], 4 * (i % 2)); end
      end
   endtask

   task automatic test_backpressure();
      int t = 0;
      do_reset();
      ready = 1'b0; ddr_en = 1'b1;
      repeat (200) @(negedge clk);
      checks++; if (beats_total !== 16) begin errors++; $display("FAIL bp_beats: got %0d expected 16", beats_total); end
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL bp_req: got %b expected 0", req); end
      checks++; if (pix_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", pix_valid); end
      checks++; if (pix_data !== 32'd0) begin errors++; $display("FAIL bp_data: got %0d expected 0", pix_data); end
      ready = 1'b1;
      get_pixels(128, 1000);
      checks++; if (pix_to) begin errors++; $display("FAIL bp_timeout: got %0d pixels expected 128", pix_q.size()); end
      for (int i = 0; i < 128; i++) begin
         checks++; if (pix_q[i] !== i) begin errors++; $display("FAIL bp_pix[%0d]: got %0d expected %0d", i, pix_q[i], i); end
      end
      while (beats_total <= 16 && t < 100) begin @(negedge clk); t++; end
      checks++; if (beats_total <= 16) begin errors++; $display("FAIL bp_resume: got %0d beats expected >16", beats_total); end
   endtask

   task automatic test_frame_start_data();
      int t = 0;
      do_reset();
      ready = 1'b0; ddr_en = 1'b1;
      do begin @(posedge clk); t++; end while (beats_total != 6 && t < 200);
      checks++; if (beats_total !== 6) begin errors++; $display("FAIL fsd_beats: got %0d expected 6", beats_total); end
      @(negedge clk);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL fsd_valid: got %b expected 0", pix_valid); end
      checks++; if (addr !== 20'd0) begin errors++; $display("FAIL fsd_addr: got %0d expected 0", addr); end
      checks++; if (req !== 1'b0) begin errors++; $display("FAIL fsd_req: got %b expected 0", req); end
      t = 0;
      while (acked_addr.size() < 3 && t < 200) begin @(negedge clk); t++; end
      checks++; if (acked_addr.size() < 3) begin errors++; $display("FAIL fsd_newreq: got %0d acks expected 3", acked_addr.size()); end
      else begin
         checks++; if (acked_addr[2] !== 20'd0) begin errors++; $display("FAIL fsd_reqaddr: got %0d expected 0", acked_addr[2]); end
      end
      ready = 1'b1;
      get_pixels(32, 400);
      for (int i = 0; i < 32; i++) begin
         checks++; if (pix_q[i] !== i) begin errors++; $display("FAIL fsd_pix[%0d]: got %0d expected %0d", i, pix_q[i], i); end
      end
   endtask

   task automatic test_frame_start_req();
      int t = 0;
      do_reset();
      ready = 1'b0; ddr_en = 1'b1;
      do begin @(posedge clk); t++; end while (ack_cnt != 1 && t < 200);
      ack_dly = 5;
      t = 0;
      do begin @(negedge clk); t++; end while (!(req && acked_addr.size() == 1) && t < 200);
      checks++; if (!(req && acked_addr.size() == 1)) begin errors++; $display("FAIL fsr_wait: got req=%b expected 1", req); end
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL fsr_req: got %b expected 1", req); end
      checks++; if (addr !== 20'd4) begin errors++; $display("FAIL fsr_addr_stable: got %0d expected 4", addr); end
      checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL fsr_valid: got %b expected 0", pix_valid); end
      repeat (2) @(negedge clk);
      checks++; if (req !== 1'b1) begin errors++; $display("FAIL fsr_req_held: got %b expected 1", req); end
      t = 0;
      while (acked_addr.size() < 3 && t < 300) begin @(negedge clk); t++; end
      checks++; if (acked_addr.size() < 3) begin errors++; $display("FAIL fsr_newreq: got %0d acks expected 3", acked_addr.size()); end
      else begin
         checks++; if (acked_addr[1] !== 20'd4) begin errors++; $display("FAIL fsr_addr1: got %0d expected 4", acked_addr[1]); end
         checks++; if (acked_addr[2] !== 20'd0) begin errors++; $display("FAIL fsr_addr2: got %0d expected 0", acked_addr[2]); end
      end
      ack_dly = 0;
      ready = 1'b1;
      get_pixels(32, 600);
      for (int i = 0; i < 32; i++) begin
         checks++; if (pix_q[i] !== i) begin errors++; $display("FAIL fsr_pix[%0d]: got %0d expected %0d", i, pix_q[i], i); end
      end
   endtask

   task automatic test_underflow();
`ifdef RD_FRAM_UNDERFLOW_CNT_EN
      int t = 0;
      do_reset();
      ready = 1'b1; ddr_en = 1'b1;
      do begin @(posedge clk); t++; end while (ack_cnt != 1 && t < 200);
      ddr_en = 1'b0;
      @(negedge clk);
      get_pixels(32, 400);
      checks++; if (gaps !== 0) begin errors++; $display("FAIL uf_gaps: got %0d expected 0", gaps); end
      checks++; if (uf !== 16'd0) begin errors++; $display("FAIL uf_pre: got %0d expected 0", uf); end
      repeat (11) @(negedge clk);
      checks++; if (uf !== 16'd10) begin errors++; $display("FAIL uf_count: got %0d expected 10", uf); end
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      checks++; if (uf !== 16'd0) begin errors++; $display("FAIL uf_clear: got %0d expected 0", uf); end
`else
      do_reset();
      ready = 1'b1; ddr_en = 1'b1;
      get_pixels(32, 400);
      ddr_en = 1'b0;
      repeat (40) @(negedge clk);
      checks++; if (uf !== 16'd0) begin errors++; $display("FAIL uf_tied: got %0d expected 0", uf); end
`endif
   endtask

   initial begin
      rst = 1'b1; frame_start = 1'b0; ready = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_frame_start_data();
      test_frame_start_req();
      test_underflow();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
